tod_counter: RTL and testbench

- Parametrised time-of-day counter for the BASYS3 clock designs. It generalises the first clock block with a configurable prescaler, a 12/24-hour display mode, edge-detected set buttons, a range-checked parallel load, and a day-rollover pulse.
- Outputs are binary. The existing binary-to-BCD converters sit downstream and drive the 7-segment mux.

---
 rtl/tod_pkg.sv | 27 ++
 rtl/tod_tick_gen.sv | 38 +++
 rtl/tod_counter.sv | 189 ++++++++++++++++++
 tb/tb_tod_counter.sv | 472 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tod_pkg.sv
// Shared widths, range limits and the 24h -> 12h display mapping for the time-of-day counter.
package tod_pkg;

    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

    localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

    // Returns {pm, disp_hour}; midnight and noon both show as 12.
    function automatic logic [HOUR_W:0] hour_to_12h(input logic [HOUR_W-1:0] h);
        logic                pm_v;
        logic [HOUR_W-1:0]   disp_v;
        pm_v = (h >= 5'd12);
        if (h == 5'd0 || h == 5'd12) begin
            disp_v = 5'd12;
        end else if (h > 5'd12) begin
            disp_v = h - 5'd12;
        end else begin
            disp_v = h;
        end
        return {pm_v, disp_v};
    endfunction

endpackage

// File: rtl/tod_tick_gen.sv
// Prescaler: counts 0..CLK_HZ-1 while en=1 and pulses tick combinationally on the wrap cycle.
// clr has priority over counting and restarts the period from zero.
module tod_tick_gen #(
    parameter int CLK_HZ = 100000000,
    parameter int CNT_W  = 27
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [CNT_W-1:0] WRAP = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = en && (cnt_q == WRAP);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tod_counter.sv
// Time-of-day counter: prescaled seconds, edge-detected set buttons, checked load, 12/24h view.
// State and pulses register one cycle after the event; alarm added by TOD_COUNTER_ALARM_EN.
module tod_counter
    import tod_pkg::*;
#(
    parameter int CLK_HZ = 100000000,
    parameter int CNT_W  = 27
`ifdef TOD_COUNTER_ALARM_EN
    ,
    parameter int ALARM_SECS = 60
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              mode_12h,
    input  logic              hrup,
    input  logic              minup,
    input  logic              load,
    input  logic [HOUR_W-1:0] load_hour,
    input  logic [MIN_W-1:0]  load_min,
    input  logic [SEC_W-1:0]  load_sec,
    output logic              load_err,
    output logic [SEC_W-1:0]  sec,
    output logic [MIN_W-1:0]  min,
    output logic [HOUR_W-1:0] hour,
    output logic [HOUR_W-1:0] disp_hour,
    output logic              pm,
    output logic              sec_tick,
    output logic              day_roll
`ifdef TOD_COUNTER_ALARM_EN
    ,
    input  logic              alarm_arm,
    input  logic [HOUR_W-1:0] alarm_hour,
    input  logic [MIN_W-1:0]  alarm_min,
    input  logic              alarm_ack,
    output logic              alarm
`endif
);

    logic [SEC_W-1:0]  sec_q, sec_d;
    logic [MIN_W-1:0]  min_q, min_d;
    logic [HOUR_W-1:0] hour_q, hour_d;
    logic              pend_q, pend_d;
    logic              minup_q, hrup_q;
    logic              load_err_q, load_err_d;
    logic              sec_tick_q, sec_tick_d;
    logic              day_roll_q, day_roll_d;

    logic              tick;
    logic              load_ok;
    logic              minup_edge;
    logic              hrup_edge;
    logic [HOUR_W:0]   h12;

    assign load_ok    = load && (load_hour <= HOUR_MAX) && (load_min <= MIN_MAX) && (load_sec <= SEC_MAX);
    assign minup_edge = minup && !minup_q;
    assign hrup_edge  = hrup && !hrup_q;

    tod_tick_gen #(
        .CLK_HZ (CLK_HZ),
        .CNT_W  (CNT_W)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clr   (load_ok),
        .tick  (tick)
    );

    // A tick displaced by a button edge is parked in pend_q; a second tick
    // arriving while one is parked still advances once and keeps the other parked.
    always_comb begin
        sec_d      = sec_q;
        min_d      = min_q;
        hour_d     = hour_q;
        pend_d     = pend_q;
        load_err_d = 1'b0;
        sec_tick_d = 1'b0;
        day_roll_d = 1'b0;
        if (load_ok) begin
            sec_d  = load_sec;
            min_d  = load_min;
            hour_d = load_hour;
            pend_d = 1'b0;
        end else begin
            load_err_d = load;
            if (minup_edge) begin
                min_d  = (min_q == MIN_MAX) ? '0 : min_q + MIN_W'(1);
                pend_d = pend_q | tick;
            end else if (hrup_edge) begin
                hour_d = (hour_q == HOUR_MAX) ? '0 : hour_q + HOUR_W'(1);
                pend_d = pend_q | tick;
            end else if (tick || pend_q) begin
                pend_d     = tick && pend_q;
                sec_tick_d = 1'b1;
                if (sec_q == SEC_MAX) begin
                    sec_d = '0;
                    if (min_q == MIN_MAX) begin
                        min_d = '0;
                        if (hour_q == HOUR_MAX) begin
                            hour_d     = '0;
                            day_roll_d = 1'b1;
                        end else begin
                            hour_d = hour_q + HOUR_W'(1);
                        end
                    end else begin
                        min_d = min_q + MIN_W'(1);
                    end
                end else begin
                    sec_d = sec_q + SEC_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_q      <= '0;
            min_q      <= '0;
            hour_q     <= '0;
            pend_q     <= 1'b0;
            minup_q    <= 1'b0;
            hrup_q     <= 1'b0;
            load_err_q <= 1'b0;
            sec_tick_q <= 1'b0;
            day_roll_q <= 1'b0;
        end else begin
            sec_q      <= sec_d;
            min_q      <= min_d;
            hour_q     <= hour_d;
            pend_q     <= pend_d;
            minup_q    <= minup;
            hrup_q     <= hrup;
            load_err_q <= load_err_d;
            sec_tick_q <= sec_tick_d;
            day_roll_q <= day_roll_d;
        end
    end

    assign h12       = hour_to_12h(hour_q);
    assign sec       = sec_q;
    assign min       = min_q;
    assign hour      = hour_q;
    assign pm        = h12[HOUR_W];
    assign disp_hour = mode_12h ? h12[HOUR_W-1:0] : hour_q;
    assign load_err  = load_err_q;
    assign sec_tick  = sec_tick_q;
    assign day_roll  = day_roll_q;

`ifdef TOD_COUNTER_ALARM_EN
    localparam int ACNT_W = (ALARM_SECS > 1) ? $clog2(ALARM_SECS) : 1;

    logic              alarm_q, alarm_d;
    logic [ACNT_W-1:0] acnt_q, acnt_d;

    // Only a real second advance can fire the alarm; loads and buttons never do.
    always_comb begin
        alarm_d = alarm_q;
        acnt_d  = acnt_q;
        if (sec_tick_d && alarm_arm && hour_d == alarm_hour && min_d == alarm_min && sec_d == '0) begin
            alarm_d = 1'b1;
            acnt_d  = '0;
        end else if (alarm_q && sec_tick_d) begin
            if (acnt_q == ACNT_W'(ALARM_SECS - 1)) begin
                alarm_d = 1'b0;
            end else begin
                acnt_d = acnt_q + ACNT_W'(1);
            end
        end
        if (alarm_ack || !alarm_arm) begin
            alarm_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_q <= 1'b0;
            acnt_q  <= '0;
        end else begin
            alarm_q <= alarm_d;
            acnt_q  <= acnt_d;
        end
    end

    assign alarm = alarm_q;
`endif

endmodule

// File: tb/tb_tod_counter.sv
// Bench for tod_counter with a seconds-of-day reference model; alarm scenario only when TOD_COUNTER_ALARM_EN is set.
module tb_tod_counter;

    localparam int CLK_HZ     = 10;
    localparam int CNT_W      = 4;
    localparam int ALARM_SECS = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic       mode_12h = 1'b0;
    logic       hrup = 1'b0;
    logic       minup = 1'b0;
    logic       load = 1'b0;
    logic [4:0] load_hour = '0;
    logic [5:0] load_min = '0;
    logic [5:0] load_sec = '0;
    logic       load_err;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic [4:0] disp_hour;
    logic       pm;
    logic       sec_tick;
    logic       day_roll;
`ifdef TOD_COUNTER_ALARM_EN
    logic       alarm_arm = 1'b0;
    logic [4:0] alarm_hour = '0;
    logic [5:0] alarm_min = '0;
    logic       alarm_ack = 1'b0;
    logic       alarm;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: time as seconds since midnight.
    int m_tod;
    int m_pre;
    bit m_pend;
    bit m_mu_prev;
    bit m_hu_prev;
    bit m_err;
    bit m_stick;
    bit m_droll;

    tod_counter #(
        .CLK_HZ (CLK_HZ),
        .CNT_W  (CNT_W)
`ifdef TOD_COUNTER_ALARM_EN
        ,
        .ALARM_SECS (ALARM_SECS)
`endif
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mode_12h  (mode_12h),
        .hrup      (hrup),
        .minup     (minup),
        .load      (load),
        .load_hour (load_hour),
        .load_min  (load_min),
        .load_sec  (load_sec),
        .load_err  (load_err),
        .sec       (sec),
        .min       (min),
        .hour      (hour),
        .disp_hour (disp_hour),
        .pm        (pm),
        .sec_tick  (sec_tick),
        .day_roll  (day_roll)
`ifdef TOD_COUNTER_ALARM_EN
        ,
        .alarm_arm  (alarm_arm),
        .alarm_hour (alarm_hour),
        .alarm_min  (alarm_min),
        .alarm_ack  (alarm_ack),
        .alarm      (alarm)
`endif
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_tod = 0; m_pre = 0; m_pend = 0;
        m_mu_prev = 0; m_hu_prev = 0;
        m_err = 0; m_stick = 0; m_droll = 0;
    endtask

    task automatic model_step();
        bit tk, mu, hu, ok;
        int h, m, s;
        tk = en && (m_pre == CLK_HZ - 1);
        mu = minup && !m_mu_prev;
        hu = hrup && !m_hu_prev;
        ok = load && (int'(load_hour) < 24) && (int'(load_min) < 60) && (int'(load_sec) < 60);
        h = m_tod / 3600;
        m = (m_tod / 60) % 60;
        s = m_tod % 60;
        m_err = load && !ok;
        m_stick = 0;
        m_droll = 0;
        if (ok) begin
            m_tod  = int'(load_hour) * 3600 + int'(load_min) * 60 + int'(load_sec);
            m_pend = 0;
            m_pre  = 0;
        end else begin
            if (en) m_pre = (m_pre + 1) % CLK_HZ;
            if (mu) begin
                m_tod  = h * 3600 + ((m + 1) % 60) * 60 + s;
                m_pend = m_pend | tk;
            end else if (hu) begin
                m_tod  = ((h + 1) % 24) * 3600 + m * 60 + s;
                m_pend = m_pend | tk;
            end else if (tk || m_pend) begin
                m_pend  = tk && m_pend;
                m_tod   = (m_tod + 1) % 86400;
                m_stick = 1;
                m_droll = (m_tod == 0);
            end
        end
        m_mu_prev = minup;
        m_hu_prev = hrup;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            model_step();
            #1;
        end
    endtask

    task automatic do_load(input int h, input int m, input int s);
        load_hour = 5'(h);
        load_min  = 6'(m);
        load_sec  = 6'(s);
        load = 1'b1;
        step(1);
        load = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        n_cmp++;
        if ({hour, min, sec, sec_tick, day_roll, load_err, disp_hour, pm} !== 26'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want 0", {hour, min, sec, sec_tick, day_roll, load_err, disp_hour, pm});
        end
        mode_12h = 1'b1;
        #1;
        n_cmp++;
        if ({pm, disp_hour} !== {1'b0, 5'd12}) begin
            n_bad++;
            $display("FAIL reset_12h: got pm=%0d disp=%0d want pm=0 disp=12", pm, disp_hour);
        end
        mode_12h = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_run_minute();
        int ticks = 0;
        en = 1'b1;
        for (int i = 0; i < 600; i++) begin
            step(1);
            if (sec_tick === 1'b1) ticks++;
        end
        n_cmp++;
        if (ticks != 60) begin
            n_bad++;
            $display("FAIL minute_tick_count: got %0d want 60", ticks);
        end
        n_cmp++;
        if ({hour, min, sec} !== {5'd0, 6'd1, 6'd0}) begin
            n_bad++;
            $display("FAIL minute_time: got %0d:%0d:%0d want 0:1:0", hour, min, sec);
        end
    endtask

    task automatic test_load_rollover();
        int rolls = 0;
        do_load(23, 59, 58);
        step(19);
        n_cmp++;
        if ({hour, min, sec} !== {5'd23, 6'd59, 6'd59}) begin
            n_bad++;
            $display("FAIL rollover_pre: got %0d:%0d:%0d want 23:59:59", hour, min, sec);
        end
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (day_roll === 1'b1) rolls++;
        end
        n_cmp++;
        if (rolls != 1) begin
            n_bad++;
            $display("FAIL day_roll_count: got %0d want 1", rolls);
        end
        n_cmp++;
        if ({hour, min, sec} !== 17'd0) begin
            n_bad++;
            $display("FAIL rollover_post: got %0d:%0d:%0d want 0:0:0", hour, min, sec);
        end
    endtask

    task automatic test_load_err();
        en = 1'b0;
        do_load(1, 2, 3);
        do_load(24, 10, 0);
        n_cmp++;
        if ({load_err, hour, min, sec} !== {1'b1, 5'd1, 6'd2, 6'd3}) begin
            n_bad++;
            $display("FAIL load_err_hour: got err=%0d %0d:%0d:%0d want err=1 1:2:3", load_err, hour, min, sec);
        end
        step(1);
        n_cmp++;
        if (load_err !== 1'b0) begin
            n_bad++;
            $display("FAIL load_err_pulse: got %0d want 0", load_err);
        end
        do_load(12, 60, 0);
        n_cmp++;
        if ({load_err, hour, min, sec} !== {1'b1, 5'd1, 6'd2, 6'd3}) begin
            n_bad++;
            $display("FAIL load_err_min: got err=%0d %0d:%0d:%0d want err=1 1:2:3", load_err, hour, min, sec);
        end
        step(1);
    endtask

    task automatic test_set_buttons();
        int changes = 0;
        logic [5:0] prev_min;
        en = 1'b0;
        do_load(5, 59, 0);
        minup = 1'b1;
        prev_min = min;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (min !== prev_min) changes++;
            prev_min = min;
        end
        minup = 1'b0;
        step(1);
        n_cmp++;
        if ({changes, hour, min, sec} !== {32'd1, 5'd5, 6'd0, 6'd0}) begin
            n_bad++;
            $display("FAIL minup_hold: got changes=%0d %0d:%0d:%0d want changes=1 5:0:0", changes, hour, min, sec);
        end
        do_load(23, 10, 20);
        hrup = 1'b1;
        step(3);
        hrup = 1'b0;
        step(1);
        n_cmp++;
        if ({hour, min, sec} !== {5'd0, 6'd10, 6'd20}) begin
            n_bad++;
            $display("FAIL hrup_wrap: got %0d:%0d:%0d want 0:10:20", hour, min, sec);
        end
        minup = 1'b1;
        hrup = 1'b1;
        step(1);
        minup = 1'b0;
        hrup = 1'b0;
        n_cmp++;
        if ({hour, min} !== {5'd0, 6'd11}) begin
            n_bad++;
            $display("FAIL both_edges: got %0d:%0d want 0:11", hour, min);
        end
        step(1);
        en = 1'b1;
        do_load(1, 2, 3);
        step(9);
        minup = 1'b1;
        step(1);
        n_cmp++;
        if ({min, sec, sec_tick} !== {6'd3, 6'd3, 1'b0}) begin
            n_bad++;
            $display("FAIL collide_edge: got min=%0d sec=%0d tick=%0d want 3 3 0", min, sec, sec_tick);
        end
        minup = 1'b0;
        step(1);
        n_cmp++;
        if ({min, sec, sec_tick} !== {6'd3, 6'd4, 1'b1}) begin
            n_bad++;
            $display("FAIL collide_pending: got min=%0d sec=%0d tick=%0d want 3 4 1", min, sec, sec_tick);
        end
    endtask

    task automatic test_12h();
        int hrs[5] = '{0, 11, 12, 13, 23};
        int dsp[5] = '{12, 11, 12, 1, 11};
        int pms[5] = '{0, 0, 1, 1, 1};
        en = 1'b0;
        mode_12h = 1'b1;
        for (int i = 0; i < 5; i++) begin
            do_load(hrs[i], 0, 0);
            n_cmp++;
            if ({pm, disp_hour} !== {1'(pms[i]), 5'(dsp[i])}) begin
                n_bad++;
                $display("FAIL map12_h%0d: got disp=%0d pm=%0d want disp=%0d pm=%0d", hrs[i], disp_hour, pm, dsp[i], pms[i]);
            end
        end
        mode_12h = 1'b0;
        #1;
        n_cmp++;
        if ({pm, disp_hour} !== {1'b1, 5'd23}) begin
            n_bad++;
            $display("FAIL map24_h23: got disp=%0d pm=%0d want disp=23 pm=1", disp_hour, pm);
        end
    endtask

    task automatic test_random();
        logic [25:0] exp_v;
        logic [25:0] got_v;
        int hh, mm, ss, dh;
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 5) == 0) minup = ~minup;
            if ($urandom_range(0, 7) == 0) hrup = ~hrup;
            if ($urandom_range(0, 31) == 0) mode_12h = ~mode_12h;
            load = ($urandom_range(0, 40) == 0);
            case ($urandom_range(0, 2))
                0: begin
                    load_hour = 5'($urandom_range(0, 31));
                    load_min  = 6'($urandom_range(0, 63));
                    load_sec  = 6'($urandom_range(0, 63));
                end
                1: begin
                    load_hour = 5'd23;
                    load_min  = 6'd59;
                    load_sec  = 6'($urandom_range(50, 59));
                end
                default: begin
                    load_hour = 5'($urandom_range(0, 23));
                    load_min  = 6'($urandom_range(0, 59));
                    load_sec  = 6'($urandom_range(0, 59));
                end
            endcase
            step(1);
            hh = m_tod / 3600;
            mm = (m_tod / 60) % 60;
            ss = m_tod % 60;
            dh = mode_12h ? ((hh % 12 == 0) ? 12 : hh % 12) : hh;
            exp_v = {5'(hh), 6'(mm), 6'(ss), m_stick, m_droll, m_err, 5'(dh), (hh >= 12)};
            got_v = {hour, min, sec, sec_tick, day_roll, load_err, disp_hour, pm};
            n_cmp++;
            if (got_v !== exp_v) begin
                n_bad++;
                $display("FAIL random_cycle%0d: got %h want %h", i, got_v, exp_v);
            end
        end
        load = 1'b0;
        minup = 1'b0;
        hrup = 1'b0;
        mode_12h = 1'b0;
        step(2);
    endtask

`ifdef TOD_COUNTER_ALARM_EN
    task automatic test_alarm();
        alarm_arm  = 1'b1;
        alarm_hour = 5'd6;
        alarm_min  = 6'd30;
        en = 1'b0;
        do_load(6, 30, 0);
        n_cmp++;
        if (alarm !== 1'b0) begin
            n_bad++;
            $display("FAIL alarm_on_load: got %0d want 0", alarm);
        end
        en = 1'b1;
        do_load(6, 29, 59);
        step(9);
        n_cmp++;
        if (alarm !== 1'b0) begin
            n_bad++;
            $display("FAIL alarm_early: got %0d want 0", alarm);
        end
        step(1);
        n_cmp++;
        if ({alarm, hour, min, sec} !== {1'b1, 5'd6, 6'd30, 6'd0}) begin
            n_bad++;
            $display("FAIL alarm_fire: got alarm=%0d %0d:%0d:%0d want 1 6:30:0", alarm, hour, min, sec);
        end
        step(3);
        alarm_ack = 1'b1;
        step(1);
        alarm_ack = 1'b0;
        n_cmp++;
        if (alarm !== 1'b0) begin
            n_bad++;
            $display("FAIL alarm_ack: got %0d want 0", alarm);
        end
        do_load(6, 29, 59);
        step(10);
        step(ALARM_SECS * CLK_HZ - 1);
        n_cmp++;
        if (alarm !== 1'b1) begin
            n_bad++;
            $display("FAIL alarm_hold: got %0d want 1", alarm);
        end
        step(1);
        n_cmp++;
        if (alarm !== 1'b0) begin
            n_bad++;
            $display("FAIL alarm_timeout: got %0d want 0", alarm);
        end
        do_load(6, 29, 59);
        step(10);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({alarm, hour, min, sec} !== 18'd0) begin
            n_bad++;
            $display("FAIL alarm_reset: got alarm=%0d %0d:%0d:%0d want all 0", alarm, hour, min, sec);
        end
        alarm_arm = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask
`endif

    task automatic test_async_reset();
        en = 1'b1;
        do_load(3, 4, 5);
        step(7);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({hour, min, sec, sec_tick, day_roll, load_err, disp_hour, pm} !== 26'd0) begin
            n_bad++;
            $display("FAIL async_reset: got %h want 0", {hour, min, sec, sec_tick, day_roll, load_err, disp_hour, pm});
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(CLK_HZ);
        n_cmp++;
        if ({hour, min, sec, sec_tick} !== {5'd0, 6'd0, 6'd1, 1'b1}) begin
            n_bad++;
            $display("FAIL after_reset_tick: got %0d:%0d:%0d tick=%0d want 0:0:1 1", hour, min, sec, sec_tick);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_run_minute();
        test_load_rollover();
        test_load_err();
        test_set_buttons();
        test_12h();
        test_random();
`ifdef TOD_COUNTER_ALARM_EN
        test_alarm();
`endif
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
